// File: rtl/mem_ctrl.sv
// mem_ctrl: load/store unit between the MEM pipeline stage and a simple
// request/acknowledge bus.
//
// An aligned access is registered, presented on the bus with lane enables and
// replicated store data, and completed on bus_ack_i or when the wait counter
// expires. A misaligned or illegal-size access never reaches the bus. It only
// raises a one-cycle exc_o.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   req_i, we_i       access request, store(1)/load(0)
//   size_i, sign_i    00 byte, 01 half, 10 word, 11 illegal; load sign-extend
//   addr_i, wdata_i   byte address, right-justified store data
//   stall_o           pipeline freeze request
//   done_o, rdata_o   completion pulse, extended load data (0 for stores)
//   exc_o, berr_o     misalignment pulse, bus timeout pulse (with done_o)
//   bus_*             request, write strobe, word address, lane enables,
//                     write data, acknowledge, read data
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | waiting for req_i; misaligned requests raise exc_o here
// BUSY  | bus_req_o held with constant address/lanes/data until ack
// DONE  | one-cycle completion (done_o, optional berr_o); req_i ignored
module mem_ctrl #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [1:0]  size_i,
  input  logic        sign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic        stall_o,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        exc_o,
  output logic        berr_o,
  output logic        bus_req_o,
  output logic        bus_we_o,
  output logic [31:0] bus_addr_o,
  output logic [3:0]  bus_sel_o,
  output logic [31:0] bus_wdata_o,
  input  logic        bus_ack_i,
  input  logic [31:0] bus_rdata_i
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;

  logic        we_q;
  logic [1:0]  size_q;
  logic        sign_q;
  logic [1:0]  addr_lo_q;
  logic [31:0] bus_addr_q;
  logic [3:0]  bus_sel_q;
  logic [31:0] bus_wdata_q;
  logic [31:0] rdata_q;
  logic        exc_q;
  logic        berr_q;
  logic [7:0]  wait_cnt;

  logic        misaligned;
  logic        accept;
  logic        ack_hit;
  logic        tmo_hit;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata;
  logic [31:0] shifted;
  logic [31:0] load_data;

  always_comb begin
    misaligned = 1'b0;
    case (size_i)
      2'b00:   misaligned = 1'b0;
      2'b01:   misaligned = addr_i[0];
      2'b10:   misaligned = (addr_i[1:0] != 2'b00);
      default: misaligned = 1'b1;
    endcase
  end

  // Lane enables and replicated store data are formed from the live inputs so
  // they can be captured in the same edge that accepts the request.
  always_comb begin
    lane_sel   = 4'b1111;
    lane_wdata = wdata_i;
    case (size_i)
      2'b00: begin
        lane_sel   = 4'b0001 << addr_i[1:0];
        lane_wdata = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        lane_sel   = addr_i[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    shifted   = bus_rdata_i >> {addr_lo_q, 3'b000};
    load_data = shifted;
    case (size_q)
      2'b00:   load_data = {{24{sign_q & shifted[7]}},  shifted[7:0]};
      2'b01:   load_data = {{16{sign_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
  end

  assign accept  = (state == IDLE) && req_i && !misaligned;
  assign ack_hit = (state == BUSY) && bus_ack_i;
  // An ack in the final wait cycle takes priority over the timeout.
  assign tmo_hit = (state == BUSY) && !bus_ack_i && (wait_cnt == WAIT_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = BUSY;
      BUSY:    if (ack_hit || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      we_q        <= 1'b0;
      size_q      <= 2'b00;
      sign_q      <= 1'b0;
      addr_lo_q   <= 2'b00;
      bus_addr_q  <= 32'h0;
      bus_sel_q   <= 4'h0;
      bus_wdata_q <= 32'h0;
      rdata_q     <= 32'h0;
      exc_q       <= 1'b0;
      berr_q      <= 1'b0;
      wait_cnt    <= 8'h0;
    end else begin
      state  <= state_nxt;
      exc_q  <= (state == IDLE) && req_i && misaligned;
      berr_q <= tmo_hit;

      if (accept) begin
        we_q        <= we_i;
        size_q      <= size_i;
        sign_q      <= sign_i;
        addr_lo_q   <= addr_i[1:0];
        bus_addr_q  <= {addr_i[31:2], 2'b00};
        bus_sel_q   <= lane_sel;
        bus_wdata_q <= lane_wdata;
        wait_cnt    <= 8'h0;
      end else if ((state == BUSY) && !bus_ack_i && !tmo_hit) begin
        wait_cnt <= wait_cnt + 8'h1;
      end

      if (ack_hit) begin
        rdata_q <= we_q ? 32'h0 : load_data;
      end else if (tmo_hit) begin
        rdata_q <= 32'h0;
      end
    end
  end

  // Gated by rst so a request presented during reset cannot freeze the pipe.
  assign stall_o     = !rst && (accept || (state == BUSY));
  assign done_o      = (state == DONE);
  assign rdata_o     = rdata_q;
  assign exc_o       = exc_q;
  assign berr_o      = berr_q;
  assign bus_req_o   = (state == BUSY);
  assign bus_we_o    = (state == BUSY) && we_q;
  assign bus_addr_o  = bus_addr_q;
  assign bus_sel_o   = bus_sel_q;
  assign bus_wdata_o = bus_wdata_q;

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL set the bus-wait cycles (2..255) before a bus error is reported.
REQ-002 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 rst  in  1  SHALL be a synchronous, active-high reset.
REQ-004 req_i  in  1  SHALL flag a load/store presented by the MEM stage.
REQ-005 we_i  in  1  SHALL select store (1) or load (0).
REQ-006 size_i  in  2  SHALL encode access size: 00 byte, 01 half, 10 word, 11 illegal.
REQ-007 sign_i  in  1  SHALL select sign-extension (1) or zero-extension (0) for loads.
REQ-008 addr_i  in  32  SHALL carry the byte address.
REQ-009 wdata_i  in  32  SHALL carry the store data, right-justified.
REQ-010 stall_o  out  1  SHALL request a pipeline freeze.
REQ-011 done_o  out  1  SHALL pulse for one cycle when an access completes, including on bus error.
REQ-012 rdata_o  out  32  SHALL carry the extended load result, valid while done_o=1.
REQ-013 exc_o  out  1  SHALL pulse for one cycle on a misaligned or illegal-size access.
REQ-014 berr_o  out  1  SHALL pulse with done_o when the access timed out.
REQ-015 bus_req_o, bus_we_o  out  1 each  SHALL be the bus request and write strobe.
REQ-016 bus_addr_o  out  32  SHALL carry the word address, with bits [1:0] forced to 0.
REQ-017 bus_sel_o  out  4  SHALL carry the byte-lane enables.
REQ-018 bus_wdata_o  out  32  SHALL carry the lane-replicated store data.
REQ-019 bus_ack_i  in  1  SHALL carry the bus completion strobe.
REQ-020 bus_rdata_i  in  32  SHALL carry the bus read word, valid with bus_ack_i.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-022 Misaligned SHALL mean: half with addr[0]=1; word with addr[1:0]!=0; or size 11.
REQ-023 IDLE with req_i=1 and an aligned access SHALL register we, size, sign, addr and wdata, and go to BUSY.
REQ-024 IDLE with req_i=1 and a misaligned access SHALL assert exc_o on the next cycle only, make no bus access, leave stall_o low, and stay in IDLE.
REQ-025 stall_o SHALL equal (IDLE & req_i & aligned) | BUSY, combinationally.
REQ-026 In BUSY, bus_req_o=1 and all bus_* outputs SHALL hold constant until bus_ack_i=1.
REQ-027 In BUSY, bus_ack_i=1 SHALL latch the formatted bus_rdata_i into rdata_o and go to DONE.
REQ-028 In DONE, done_o SHALL be 1, stall_o SHALL be 0, and req_i SHALL be ignored; the next state SHALL be IDLE.
REQ-029 Minimum latency SHALL be: accept at cycle N, bus_req_o at N+1, ack at N+1, done_o at N+2 (two stall cycles).
REQ-030 Byte-lane enables (little-endian) SHALL be: byte 0001<<addr[1:0]; half 0011 (addr[1]=0) or 1100 (addr[1]=1); word 1111.
REQ-031 Store data SHALL be replicated: byte as {4{wdata[7:0]}}, half as {2{wdata[15:0]}}, word unchanged.
REQ-032 Load data SHALL be shifted right by 8*addr[1:0] and then sign- or zero-extended from bit 7 (byte) or bit 15 (half).
REQ-033 For a store, rdata_o SHALL be 0 at done_o.
REQ-034 A wait counter SHALL clear on entry to BUSY and increment each BUSY cycle without ack.
REQ-035 When the wait counter reaches TIMEOUT-1 without ack, the block SHALL drop bus_req_o and go to DONE with berr_o=1 and rdata_o=0.
REQ-036 An ack arriving in the same cycle the timeout is reached SHALL win: normal completion, berr_o=0.
REQ-037 bus_ack_i SHALL be ignored in IDLE and in DONE.

Reset
REQ-038 While rst=1 at a clock edge, the next state SHALL be IDLE, and stall_o, done_o, exc_o, berr_o, bus_req_o, bus_we_o SHALL all be 0.
REQ-039 While rst=1 at a clock edge, bus_addr_o, bus_sel_o, bus_wdata_o, rdata_o and the wait counter SHALL all be 0.
REQ-040 Reset asserted in BUSY SHALL abort the access without done_o; a late bus_ack_i after reset SHALL be ignored.

Verification
REQ-041 Load byte, addr=0x1003, sign=1, ack one cycle after request, bus_rdata=0x80FFFFFF -> bus_sel=1000, rdata_o=0xFFFFFF80, done_o at N+2.
REQ-042 Store half, addr=0x2002, wdata=0x0000ABCD -> bus_sel=1100, bus_wdata=0xABCDABCD, bus_we=1, stall_o high for exactly 2 cycles.
REQ-043 Load word, addr=0x3001 -> exc_o pulse at N+1, bus_req_o never asserted, stall_o=0.
REQ-044 Load word, ack never arrives, TIMEOUT=16 -> berr_o and done_o pulse together, bus_req_o high for 16 cycles, rdata_o=0.
REQ-045 rst asserted on the 3rd BUSY cycle, then ack driven high -> IDLE, no done_o, all outputs 0.
REQ-046 Back-to-back aligned load then store, each acked at once -> two separate done_o pulses, IDLE visited between them.
